// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM-subset control FSM, condition check and NZCV flags
module multicycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, UNDEF
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       is_cmp;
  logic       unused_instr_bits;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign is_cmp = (cmd == 4'b1010);
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  // Raw per-state controls, before condition gating
  logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op;
  logic [1:0] flag_w;
  logic       cond_ex, pcs;

  // Next-state sequencing
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNDEF;
        endcase
      end
      MEMADR:       state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:      state_d = MEMWB;
      EXECR, EXECI: state_d = ALUWB;
      default:      state_d = FETCH;
    endcase
  end

  // Moore per-state datapath selects and raw enables
  always_comb begin
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR:    alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:    reg_w = ~is_cmp;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU operation and flag-write request from the data-processing command
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0010, 4'b1010: ALUControl = 2'b01;
        4'b0000:          ALUControl = 2'b10;
        4'b1100:          ALUControl = 2'b11;
        default:          ALUControl = 2'b00;
      endcase
      flag_w[1] = funct[0] | is_cmp;
      flag_w[0] = (funct[0] & (cmd == 4'b0100 || cmd == 4'b0010 || is_cmp)) | is_cmp;
    end
  end

  // Condition evaluation against the stored NZCV flags
  always_comb begin
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = ~(~flags_q[2] & (flags_q[3] == flags_q[0]));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Condition-gated enables; held low while reset is asserted
  always_comb begin
    pcs      = branch | (reg_w & (rd == 4'hF));
    PCWrite  = rst_n & (next_pc | (pcs & cond_ex));
    RegWrite = rst_n & reg_w & cond_ex;
    MemWrite = rst_n & mem_w & cond_ex;
    IRWrite  = rst_n & ir_w;
    ImmSrc   = (op == 2'b11) ? 2'b00 : op;
    RegSrc   = {op == 2'b01, op == 2'b10};
    flags_d  = flags_q;
    if (flag_w[1] & cond_ex) flags_d[3:2] = ALUFlags[3:2];
    if (flag_w[0] & cond_ex) flags_d[1:0] = ALUFlags[1:0];
  end

  // State and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule
